tmds_decoder: RTL and testbench

TMDS_DECODER -- requirements
Module: tmds_decoder

---
 rtl/tmds_pkg.sv | 28 ++
 rtl/tmds_symbol_decode.sv | 45 ++++
 rtl/tmds_decoder.sv | 182 ++++++++++++++++++
 tb/tb_tmds_decoder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tmds_pkg
// Description : Shared TMDS definitions: word width, the four control-token
//               code words (identical to the ones the TMDS encoder emits) and
//               the word-alignment state encoding used by the decoder.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package tmds_pkg;

  localparam int TMDS_WORD_W = 10;

  // Control tokens, indexed by the {c1,c0} pair they carry.
  localparam logic [TMDS_WORD_W-1:0] CTRL_TOKEN_00 = 10'b1101010100;
  localparam logic [TMDS_WORD_W-1:0] CTRL_TOKEN_01 = 10'b0010101011;
  localparam logic [TMDS_WORD_W-1:0] CTRL_TOKEN_10 = 10'b0101010100;
  localparam logic [TMDS_WORD_W-1:0] CTRL_TOKEN_11 = 10'b1010101011;

  typedef enum logic [1:0] {
    ST_SEARCH    = 2'd0,
    ST_SLIP_HOLD = 2'd1,
    ST_VERIFY    = 2'd2,
    ST_LOCKED    = 2'd3
  } align_state_t;

endpackage
`default_nettype wire

// File: rtl/tmds_symbol_decode.sv
`default_nettype none
// ============================================================================
// Module      : tmds_symbol_decode
// Description : Purely combinational TMDS word decoder. Control tokens are
//               matched exactly; every other word is decoded as video.
// Ports       : word     in  [9:0] received TMDS word (bit 0 first on wire)
//               is_ctrl  out       1 when word is one of the control tokens
//               control  out [1:0] decoded control pair (valid when is_ctrl)
//               data     out [7:0] decoded video byte (0 for control tokens)
// Revision    : 1.0 - initial release
// ============================================================================
module tmds_symbol_decode
  import tmds_pkg::*;
(
  input  logic [TMDS_WORD_W-1:0] word,
  output logic                   is_ctrl,
  output logic [1:0]             control,
  output logic [7:0]             data
);

  logic [7:0] d;

  always_comb begin
    is_ctrl = 1'b1;
    control = 2'b00;
    data    = 8'h00;
    d       = word[9] ? ~word[7:0] : word[7:0];
    case (word)
      CTRL_TOKEN_00: control = 2'b00;
      CTRL_TOKEN_01: control = 2'b01;
      CTRL_TOKEN_10: control = 2'b10;
      CTRL_TOKEN_11: control = 2'b11;
      default: begin
        is_ctrl = 1'b0;
        // bit 8 tells whether the encoder chained bits with XOR (1) or XNOR (0)
        data[0] = d[0];
        for (int i = 1; i < 8; i++) begin
          data[i] = word[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/tmds_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tmds_decoder
// Description : TMDS channel decoder with word-alignment FSM. Decoded data is
//               registered with one cycle of latency. The alignment FSM looks
//               for runs of control tokens, requests bit slips from the
//               deserializer while searching, and drops lock when tokens stop
//               arriving for SEARCH_WINDOW cycles.
// Macro       : TMDS_DECODER_LOSS_CNT_EN - when defined, o_lock_loss_cnt
//               counts LOCKED->SEARCH transitions (saturating); otherwise it
//               is tied to zero.
// Ports       : i_clk            in        pixel clock
//               i_rst            in        synchronous active-high reset
//               i_tmds           in  [9:0] one TMDS word per cycle
//               o_data           out [7:0] decoded video byte
//               o_control        out [1:0] decoded control pair {vs,hs}
//               o_ve             out       1 = video word, 0 = control token
//               o_locked         out       word alignment achieved
//               o_bitslip        out       one-cycle bit-slip request
//               o_lock_loss_cnt  out [7:0] lock-loss count
// Revision    : 1.0 - initial release
// ============================================================================
module tmds_decoder
  import tmds_pkg::*;
#(
  parameter int SEARCH_WINDOW = 4096,
  parameter int CTRL_RUN      = 8,
  parameter int SLIP_WAIT     = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [TMDS_WORD_W-1:0] i_tmds,
  output logic [7:0]             o_data,
  output logic [1:0]             o_control,
  output logic                   o_ve,
  output logic                   o_locked,
  output logic                   o_bitslip,
  output logic [7:0]             o_lock_loss_cnt
);

  localparam logic [15:0] WIN_LAST   = 16'(SEARCH_WINDOW - 1);
  localparam logic [15:0] HOLD_LAST  = 16'(SLIP_WAIT - 1);
  localparam logic [7:0]  RUN_TARGET = 8'(CTRL_RUN);

  logic         sym_is_ctrl;
  logic [1:0]   sym_control;
  logic [7:0]   sym_data;

  // Registered "token seen" flag that drives the FSM; kept apart from o_ve
  // so that the reset value of o_ve (0) is not mistaken for a token.
  logic         ctrl_seen;

  align_state_t state, state_next;
  logic [15:0]  win_cnt, win_cnt_next;
  logic [7:0]   run_cnt, run_cnt_next;
  logic         bitslip_next;

  tmds_symbol_decode u_symbol_decode (
    .word    (i_tmds),
    .is_ctrl (sym_is_ctrl),
    .control (sym_control),
    .data    (sym_data)
  );

  // Decode path: always valid, independent of alignment state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_data    <= 8'h00;
      o_control <= 2'b00;
      o_ve      <= 1'b0;
      ctrl_seen <= 1'b0;
    end else begin
      o_data    <= sym_data;
      o_ve      <= ~sym_is_ctrl;
      ctrl_seen <= sym_is_ctrl;
      if (sym_is_ctrl) begin
        o_control <= sym_control;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= ST_SEARCH;
      win_cnt   <= 16'd0;
      run_cnt   <= 8'd0;
      o_bitslip <= 1'b0;
      o_locked  <= 1'b0;
    end else begin
      state     <= state_next;
      win_cnt   <= win_cnt_next;
      run_cnt   <= run_cnt_next;
      o_bitslip <= bitslip_next;
      o_locked  <= (state_next == ST_LOCKED);
    end
  end

  always_comb begin
    state_next   = state;
    win_cnt_next = win_cnt;
    run_cnt_next = run_cnt;
    bitslip_next = 1'b0;
    case (state)
      ST_SEARCH: begin
        if (ctrl_seen) begin
          win_cnt_next = 16'd0;
          if (RUN_TARGET == 8'd1) begin
            state_next   = ST_LOCKED;
            run_cnt_next = 8'd0;
          end else begin
            state_next   = ST_VERIFY;
            run_cnt_next = 8'd1;
          end
        end else if (win_cnt == WIN_LAST) begin
          state_next   = ST_SLIP_HOLD;
          win_cnt_next = 16'd0;
          bitslip_next = 1'b1;
        end else if (win_cnt != 16'hFFFF) begin
          win_cnt_next = win_cnt + 16'd1;
        end
      end
      ST_SLIP_HOLD: begin
        // Deserializer output is unsettled right after a slip; ignore words.
        if (win_cnt == HOLD_LAST) begin
          state_next   = ST_SEARCH;
          win_cnt_next = 16'd0;
        end else begin
          win_cnt_next = win_cnt + 16'd1;
        end
      end
      ST_VERIFY: begin
        win_cnt_next = 16'd0;
        if (ctrl_seen) begin
          if ((run_cnt + 8'd1) == RUN_TARGET) begin
            state_next   = ST_LOCKED;
            run_cnt_next = 8'd0;
          end else begin
            run_cnt_next = run_cnt + 8'd1;
          end
        end else begin
          state_next   = ST_SEARCH;
          run_cnt_next = 8'd0;
        end
      end
      ST_LOCKED: begin
        if (ctrl_seen) begin
          win_cnt_next = 16'd0;
        end else if (win_cnt == WIN_LAST) begin
          // Lock lost: re-search without slipping, alignment may still be good.
          state_next   = ST_SEARCH;
          win_cnt_next = 16'd0;
        end else if (win_cnt != 16'hFFFF) begin
          win_cnt_next = win_cnt + 16'd1;
        end
      end
      default: begin
        state_next   = ST_SEARCH;
        win_cnt_next = 16'd0;
        run_cnt_next = 8'd0;
      end
    endcase
  end

`ifdef TMDS_DECODER_LOSS_CNT_EN
  logic [7:0] loss_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      loss_cnt <= 8'd0;
    end else if ((state == ST_LOCKED) && (state_next == ST_SEARCH) &&
                 (loss_cnt != 8'hFF)) begin
      loss_cnt <= loss_cnt + 8'd1;
    end
  end

  assign o_lock_loss_cnt = loss_cnt;
`else
  assign o_lock_loss_cnt = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tmds_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_tmds_decoder
// Description : Self-checking bench for tmds_decoder. Directed alignment
//               scenarios (lock, data decode, lock loss, VERIFY abort,
//               bit-slip cadence, reset during a slip) followed by a random
//               TMDS-encoder loopback against a queue-free expected model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tmds_decoder;

  localparam int SW  = 16;
  localparam int CR  = 8;
  localparam int SWT = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] tmds;
  logic [7:0] o_data;
  logic [1:0] o_control;
  logic       o_ve;
  logic       o_locked;
  logic       o_bitslip;
  logic [7:0] o_lock_loss_cnt;

  int compared   = 0;
  int mismatched = 0;

  logic [9:0] tok [4] = '{10'b1101010100, 10'b0010101011,
                          10'b0101010100, 10'b1010101011};

  tmds_decoder #(
    .SEARCH_WINDOW (SW),
    .CTRL_RUN      (CR),
    .SLIP_WAIT     (SWT)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_tmds          (tmds),
    .o_data          (o_data),
    .o_control       (o_control),
    .o_ve            (o_ve),
    .o_locked        (o_locked),
    .o_bitslip       (o_bitslip),
    .o_lock_loss_cnt (o_lock_loss_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_word(input string tag, input logic ve, input logic [1:0] ctrl,
                             input logic [7:0] data);
    chk({tag, "_ve"},   32'(o_ve),      32'(ve));
    chk({tag, "_ctrl"}, 32'(o_control), 32'(ctrl));
    chk({tag, "_data"}, 32'(o_data),    32'(data));
  endtask

  task automatic expect_align(input string tag, input logic locked, input logic slip);
    chk({tag, "_locked"},  32'(o_locked),  32'(locked));
    chk({tag, "_bitslip"}, 32'(o_bitslip), 32'(slip));
  endtask

  task automatic expect_reset_state(input string tag);
    expect_word(tag, 1'b0, 2'b00, 8'h00);
    expect_align(tag, 1'b0, 1'b0);
    chk({tag, "_losscnt"}, 32'(o_lock_loss_cnt), 32'd0);
  endtask

  // Drive one word, let the DUT capture it, sample just after the edge.
  task automatic step(input logic [9:0] w);
    tmds = w;
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_token(input logic [9:0] w);
    return (w == 10'b1101010100) || (w == 10'b0010101011) ||
           (w == 10'b0101010100) || (w == 10'b1010101011);
  endfunction

  // Reference TMDS video encoder; inv selects the optional bit-9 inversion.
  function automatic logic [9:0] encode(input logic [7:0] d, input bit inv);
    int         n1;
    bit         use_xnor;
    logic [8:0] qm;
    n1       = $countones(d);
    use_xnor = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    qm[0]    = d[0];
    for (int i = 1; i < 8; i++) begin
      qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    end
    qm[8] = ~use_xnor;
    return {inv, qm[8], inv ? ~qm[7:0] : qm[7:0]};
  endfunction

  initial begin
    logic [7:0] exp_loss;
    logic [1:0] last_ctrl;
    logic [7:0] rbyte;
    logic [1:0] pair;
    logic [9:0] w;
    int         first_slip;
    int         second_slip;

`ifdef TMDS_DECODER_LOSS_CNT_EN
    exp_loss = 8'd1;
`else
    exp_loss = 8'd0;
`endif

    // ---- reset with a token on the input: outputs must stay zero
    rst = 1'b1;
    step(tok[3]);
    step(tok[3]);
    expect_reset_state("reset");
    rst = 1'b0;

    // ---- lock on CR tokens; o_locked one cycle after the last is registered
    for (int k = 1; k <= CR; k++) begin
      step(tok[0]);
      expect_word($sformatf("lock_tok%0d", k), 1'b0, 2'b00, 8'h00);
      expect_align($sformatf("lock_tok%0d", k), 1'b0, 1'b0);
    end
    step(10'b0100000000);
    expect_word("vid_0100000000", 1'b1, 2'b00, 8'h00);
    expect_align("locked_after_run", 1'b1, 1'b0);
    step(10'b1111111111);
    expect_word("vid_1111111111", 1'b1, 2'b00, 8'h00);
    step(10'b1000000000);
    expect_word("vid_1000000000", 1'b1, 2'b00, 8'hFF);
    chk("losscnt_before_loss", 32'(o_lock_loss_cnt), 32'd0);

    // ---- lock loss: SW token-free words seen by the FSM drop lock, no slip
    for (int k = 4; k <= SW; k++) begin
      step(10'b1000000000);
      expect_align($sformatf("locked_hold%0d", k), 1'b1, 1'b0);
    end
    step(10'b1000000000);
    expect_align("lock_lost", 1'b0, 1'b0);
    chk("losscnt_after_loss", 32'(o_lock_loss_cnt), 32'(exp_loss));

    // ---- VERIFY aborted by a video word; a full fresh run is needed again
    rst = 1'b1;
    step(tok[0]);
    expect_reset_state("reset2");
    rst = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step(tok[1]);
      expect_word($sformatf("verify_tok%0d", k), 1'b0, 2'b01, 8'h00);
    end
    step(10'b0100000000);
    expect_word("verify_abort_vid", 1'b1, 2'b01, 8'h00);
    for (int k = 1; k <= CR; k++) begin
      step(tok[2]);
      expect_align($sformatf("relock_tok%0d", k), 1'b0, 1'b0);
    end
    step(10'b0100000000);
    expect_word("relock_vid", 1'b1, 2'b10, 8'h00);
    expect_align("relock", 1'b1, 1'b0);

    // ---- bit-slip cadence with video only
    rst = 1'b1;
    step(10'b0100000000);
    rst = 1'b0;
    first_slip  = SW;
    second_slip = SW + SWT + SW;
    for (int s = 1; s <= second_slip + 4; s++) begin
      step(10'b0100000000);
      expect_align($sformatf("slip_s%0d", s), 1'b0,
                   (s == first_slip) || (s == second_slip));
    end

    // ---- reset landing right after the bit-slip cycle
    rst = 1'b1;
    step(10'b0100000000);
    rst = 1'b0;
    for (int s = 1; s <= SW; s++) begin
      step(10'b0100000000);
    end
    expect_align("slip_before_reset", 1'b0, 1'b1);
    rst = 1'b1;
    step(tok[3]);
    expect_reset_state("reset_in_slip");
    rst = 1'b0;
    for (int s = 1; s <= SW + 1; s++) begin
      step(10'b0100000000);
      expect_align($sformatf("slip_after_reset_s%0d", s), 1'b0, s == SW);
    end

    // ---- random encoder loopback with blanking tokens
    rst = 1'b1;
    step(10'b0100000000);
    rst = 1'b0;
    last_ctrl = 2'b00;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        pair = 2'($urandom_range(0, 3));
        step(tok[pair]);
        last_ctrl = pair;
        expect_word($sformatf("loop%0d_ctrl", i), 1'b0, pair, 8'h00);
      end else begin
        rbyte = 8'($urandom);
        w     = encode(rbyte, bit'($urandom_range(0, 1)));
        for (int t = 0; t < 8 && is_token(w); t++) begin
          rbyte = 8'($urandom);
          w     = encode(rbyte, 1'b0);
        end
        step(w);
        expect_word($sformatf("loop%0d_vid", i), 1'b1, last_ctrl, rbyte);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
